ro_sched: RTL

Parametrised multi-channel readout scheduler for the cochlea core array. It holds per-channel event and polarity bits in capture registers and time-multiplexes them onto one registered output bus. Slot ownership follows a shared gray counter: whichever counter bit toggles on a cycle names the channel read that cycle, so channel 0 is read most often. It supersedes per-core edge-triggered tristate readout and adds capture and overflow flagging, channel masking, and a frame marker.

---
 rtl/ro_pkg.sv | 20 ++
 rtl/ro_gray_slot.sv | 37 +++
 rtl/ro_sched.sv | 102 ++++++++++
 3 files changed

// File: rtl/ro_pkg.sv
// rtl/ro_pkg.sv - shared constants and slot helpers for the readout scheduler
package ro_pkg;

  localparam int DW_DEF = 2;

  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Trailing ones of b, capped at n_ch-1: the gray bit that flips on b+1.
  function automatic int slot_of(input logic [15:0] b, input int n_ch);
    int s;
    s = 0;
    for (int i = 0; i < 15; i++) begin
      if (s == i && i < n_ch - 1 && b[i]) s = i + 1;
    end
    return s;
  endfunction

endpackage

// File: rtl/ro_gray_slot.sv
// rtl/ro_gray_slot.sv - binary/gray counter with slot index and wrap flag
module ro_gray_slot
  import ro_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int CW   = ch_w(N_CH)
) (
  input  logic            clk_master,
  input  logic            reset,
  input  logic            en,
  output logic [N_CH-1:0] gray,
  output logic [CW-1:0]   slot,
  output logic            wrap
);

  logic [N_CH-1:0] b_q, b_d, gray_q;

  always_comb begin
    b_d = b_q;
    if (en) b_d = b_q + 1'b1;
  end

  always_ff @(posedge clk_master) begin
    if (reset) begin
      b_q    <= '0;
      gray_q <= '0;
    end else begin
      b_q    <= b_d;
      gray_q <= b_d ^ (b_d >> 1);
    end
  end

  assign gray = gray_q;
  assign slot = CW'(slot_of(16'(b_q), N_CH));
  assign wrap = &b_q;

endmodule

// File: rtl/ro_sched.sv
// rtl/ro_sched.sv - per-channel capture registers time-multiplexed onto one output bus
module ro_sched
  import ro_pkg::*;
#(
  parameter int N_CH = 8,
  parameter int DW   = DW_DEF,
  localparam int CW  = ch_w(N_CH)
) (
  input  logic               clk_master,
  input  logic               reset,
  input  logic               en,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [N_CH-1:0]    in_valid,
  input  logic [N_CH*DW-1:0] in_data,
  output logic [N_CH-1:0]    gray,
  output logic               out_valid,
  output logic [DW-1:0]      out_data,
  output logic [CW-1:0]      out_ch,
  output logic               out_ovf,
  output logic               frame_start
);

  logic [CW-1:0]   slot;
  logic            wrap;
  logic            rd_ok;
  logic [N_CH-1:0] rd_vec;
  logic [DW-1:0]   hold_q [N_CH];
  logic [DW-1:0]   hold_d [N_CH];
  logic [N_CH-1:0] full_q, full_d, ovf_q, ovf_d;
  logic            out_valid_q, out_ovf_q, frame_q;
  logic [DW-1:0]   out_data_q;
  logic [CW-1:0]   out_ch_q;

  ro_gray_slot #(.N_CH(N_CH), .CW(CW)) u_gray_slot (
    .clk_master (clk_master),
    .reset      (reset),
    .en         (en),
    .gray       (gray),
    .slot       (slot),
    .wrap       (wrap)
  );

  assign rd_ok = en & ch_mask[slot] & full_q[slot];

  always_comb begin
    rd_vec = '0;
    if (rd_ok) rd_vec[slot] = 1'b1;
  end

  // A capture landing on a valid read refills the register without flagging overflow.
  always_comb begin
    hold_d = hold_q;
    full_d = full_q;
    ovf_d  = ovf_q;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_vec[i]) begin
        full_d[i] = 1'b0;
        ovf_d[i]  = 1'b0;
      end
      if (in_valid[i]) begin
        hold_d[i] = in_data[i*DW +: DW];
        full_d[i] = 1'b1;
        if (full_q[i] && !rd_vec[i]) ovf_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_master) begin
    if (reset) begin
      hold_q      <= '{default: '0};
      full_q      <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_ovf_q   <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      hold_q <= hold_d;
      full_q <= full_d;
      ovf_q  <= ovf_d;
      if (en) begin
        out_valid_q <= rd_ok;
        out_data_q  <= rd_ok ? hold_q[slot] : '0;
        out_ovf_q   <= rd_ok & ovf_q[slot];
        out_ch_q    <= slot;
        frame_q     <= wrap;
      end else begin
        out_valid_q <= 1'b0;
        out_ovf_q   <= 1'b0;
        frame_q     <= 1'b0;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_ch      = out_ch_q;
  assign out_ovf     = out_ovf_q;
  assign frame_start = frame_q;

endmodule
